// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions used by the transmitter and receiver
package uart_pkg;

    localparam int   UART_DATA_WIDTH = 8;
    localparam int   PRESCALE_W      = 5;

    localparam logic PARITY_EVEN     = 1'b0;
    localparam logic PARITY_ODD      = 1'b1;

    localparam logic IDLE_LEVEL      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// rtl/uart_tx_baud_cnt.sv - loadable down-counter giving a one-cycle bit_done every load_val cycles
module uart_tx_baud_cnt
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] load_val,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // bit_done fires on the last cycle of a bit; the counter reloads on that same edge
    always_comb begin
        cnt_d    = cnt_q;
        bit_done = enable && (cnt_q == PRESCALE_W'(1));
        if (load || bit_done) begin
            cnt_d = load_val;
        end else if (enable) begin
            cnt_d = cnt_q - PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_valid,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  S_Data,
    output logic                  Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  parity_en_q, parity_en_d;
    logic                  parity_bit_q, parity_bit_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  s_data_q, s_data_d;
    logic                  busy_q, busy_d;
    logic [PRESCALE_W-1:0] presc_eff;
    logic [PRESCALE_W-1:0] baud_load_val;
    logic                  accept;
    logic                  bit_done;

    assign presc_eff     = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
    assign accept        = (state_q == ST_IDLE) && Data_valid;
    assign baud_load_val = accept ? presc_eff : prescale_q;

    uart_tx_baud_cnt u_baud_cnt (
        .clk      (CLK),
        .reset    (Reset),
        .load     (accept),
        .enable   (state_q != ST_IDLE),
        .load_val (baud_load_val),
        .bit_done (bit_done)
    );

    // Line and Busy are registered from the next-state decision, so the
    // start bit appears on the very edge that accepts the frame.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        parity_en_d  = parity_en_q;
        parity_bit_d = parity_bit_q;
        prescale_d   = prescale_q;
        s_data_d     = s_data_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (Data_valid) begin
                    state_d      = ST_START;
                    shift_d      = P_Data;
                    parity_en_d  = Parity_EN;
                    parity_bit_d = (^P_Data) ^ (Parity_type == PARITY_ODD);
                    prescale_d   = presc_eff;
                    s_data_d     = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    s_data_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        if (parity_en_q) begin
                            state_d  = ST_PARITY;
                            s_data_d = parity_bit_q;
                        end else begin
                            state_d  = ST_STOP;
                            s_data_d = IDLE_LEVEL;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        s_data_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d  = ST_STOP;
                    s_data_d = IDLE_LEVEL;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d  = ST_IDLE;
                    s_data_d = IDLE_LEVEL;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                s_data_d = IDLE_LEVEL;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            prescale_q   <= '0;
            s_data_q     <= IDLE_LEVEL;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            parity_en_q  <= parity_en_d;
            parity_bit_q <= parity_bit_d;
            prescale_q   <= prescale_d;
            s_data_q     <= s_data_d;
            busy_q       <= busy_d;
        end
    end

    assign S_Data = s_data_q;
    assign Busy   = busy_q;

endmodule
